lisnoc_packet_tx: RTL and testbench

Packetizing network adapter that sits directly upstream of a mesh link input (linkN_in_*) and turns a send request plus a stream of payload words into a lisnoc worm: one header flit followed by payload flits. It drives one virtual channel of the link, holds every flit stable until the router accepts it, and sustains one flit per cycle when the router does not backpressure. It also counts completed packets for software-visible statistics.

---
 rtl/lisnoc_packet_tx_pkg.sv | 20 ++
 rtl/lisnoc_packet_tx.sv | 118 +++++++++++
 tb/tb_lisnoc_packet_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lisnoc_packet_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lisnoc_packet_tx_pkg
// Description : Flit type codes and FSM encoding for the lisnoc packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
package lisnoc_packet_tx_pkg;

    typedef logic [1:0] flit_type_t;

    localparam flit_type_t c_flit_payload = 2'b00;
    localparam flit_type_t c_flit_header  = 2'b01;
    localparam flit_type_t c_flit_last    = 2'b10;
    localparam flit_type_t c_flit_single  = 2'b11;

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_payload = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lisnoc_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : lisnoc_packet_tx
// Description : Turns a send request plus payload words into a lisnoc worm
//               on one virtual channel, and counts completed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module lisnoc_packet_tx
    import lisnoc_packet_tx_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int PH_DEST_WIDTH   = 5,
    parameter int LEN_WIDTH       = 8,
    parameter int VCHANNELS       = 1,
    parameter int USE_VCHANNEL    = 0,
    localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [PH_DEST_WIDTH-1:0]   req_dest_i,
    input  logic [LEN_WIDTH-1:0]       req_len_i,
    input  logic [FLIT_DATA_WIDTH-1:0] data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    output logic [FLIT_WIDTH-1:0]      flit_o,
    output logic [VCHANNELS-1:0]       valid_o,
    input  logic [VCHANNELS-1:0]       ready_i,
    output logic                       busy_o,
    output logic [15:0]                pkt_cnt_o
);

    logic [0:0]                 r_state;
    logic                       r_out_v;
    logic [FLIT_TYPE_WIDTH-1:0] r_out_type;
    logic [FLIT_DATA_WIDTH-1:0] r_out_data;
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic [15:0]                r_pkt_cnt;

    logic                       w_free;
    logic                       w_req_hs;
    logic                       w_dat_hs;
    logic                       w_out_hs;
    logic                       w_last_word;
    logic                       w_out_is_tail;
    logic [FLIT_DATA_WIDTH-1:0] w_hdr;

    // The output register can take a new flit if empty or draining this cycle.
    assign w_free        = !r_out_v || ready_i[USE_VCHANNEL];
    assign w_req_hs      = (r_state == c_st_idle) && w_free && req_valid_i;
    assign w_dat_hs      = (r_state == c_st_payload) && w_free && data_valid_i;
    assign w_out_hs      = r_out_v && ready_i[USE_VCHANNEL];
    assign w_last_word   = (r_remaining == LEN_WIDTH'(1));
    assign w_out_is_tail = (r_out_type == FLIT_TYPE_WIDTH'(c_flit_last)) ||
                           (r_out_type == FLIT_TYPE_WIDTH'(c_flit_single));

    always_comb begin
        w_hdr = '0;
        w_hdr[FLIT_DATA_WIDTH-1 -: PH_DEST_WIDTH] = req_dest_i;
        w_hdr[LEN_WIDTH-1:0] = req_len_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_out_v     <= 1'b0;
            r_out_type  <= '0;
            r_out_data  <= '0;
            r_remaining <= '0;
        end else if (w_req_hs) begin
            r_out_v     <= 1'b1;
            r_out_data  <= w_hdr;
            r_remaining <= req_len_i;
            if (req_len_i == '0) begin
                r_out_type <= FLIT_TYPE_WIDTH'(c_flit_single);
                r_state    <= c_st_idle;
            end else begin
                r_out_type <= FLIT_TYPE_WIDTH'(c_flit_header);
                r_state    <= c_st_payload;
            end
        end else if (w_dat_hs) begin
            r_out_v     <= 1'b1;
            r_out_data  <= data_i;
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (w_last_word) begin
                r_out_type <= FLIT_TYPE_WIDTH'(c_flit_last);
                r_state    <= c_st_idle;
            end else begin
                r_out_type <= FLIT_TYPE_WIDTH'(c_flit_payload);
            end
        end else if (w_out_hs) begin
            r_out_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (w_out_hs && w_out_is_tail) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    always_comb begin
        valid_o = '0;
        valid_o[USE_VCHANNEL] = r_out_v;
    end

    assign req_ready_o  = (r_state == c_st_idle) && w_free;
    assign data_ready_o = (r_state == c_st_payload) && w_free;
    assign flit_o       = {r_out_type, r_out_data};
    assign busy_o       = (r_state == c_st_payload) || r_out_v;
    assign pkt_cnt_o    = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lisnoc_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lisnoc_packet_tx
// Description : Directed, table-driven bench for lisnoc_packet_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lisnoc_packet_tx;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_dest;
    logic [7:0]  req_len;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [33:0] flit;
    logic [0:0]  valid;
    logic [0:0]  ready;
    logic        busy;
    logic [15:0] pkt_cnt;

    logic        req_valid2;
    logic        req_ready2;
    logic        data_ready2;
    logic [33:0] flit2;
    logic [1:0]  valid2;
    logic [1:0]  ready2;
    logic        busy2;
    logic [15:0] pkt_cnt2;

    int n_checks;
    int n_errors;

    lisnoc_packet_tx dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_dest_i(req_dest), .req_len_i(req_len),
        .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready),
        .flit_o(flit), .valid_o(valid), .ready_i(ready),
        .busy_o(busy), .pkt_cnt_o(pkt_cnt)
    );

    lisnoc_packet_tx #(.VCHANNELS(2), .USE_VCHANNEL(1)) dut_vc (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .req_dest_i(5'd1), .req_len_i(8'd0),
        .data_i(32'd0), .data_valid_i(1'b0), .data_ready_o(data_ready2),
        .flit_o(flit2), .valid_o(valid2), .ready_i(ready2),
        .busy_o(busy2), .pkt_cnt_o(pkt_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rv;
        logic [4:0]  dest;
        logic [7:0]  len;
        logic [31:0] d;
        logic        dv;
        logic        rdy;
        logic        e_rr;
        logic        e_dr;
        logic        e_v;
        logic [1:0]  e_type;
        logic [31:0] e_data;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [4:0] dest, input logic [7:0] len,
                                input logic [31:0] d, input logic dv, input logic rdy,
                                input logic e_rr, input logic e_dr, input logic e_v,
                                input logic [1:0] e_type, input logic [31:0] e_data,
                                input logic e_busy, input logic [15:0] e_cnt);
        vec_t v;
        v.rv = rv; v.dest = dest; v.len = len; v.d = d; v.dv = dv; v.rdy = rdy;
        v.e_rr = e_rr; v.e_dr = e_dr; v.e_v = e_v; v.e_type = e_type;
        v.e_data = e_data; v.e_busy = e_busy; v.e_cnt = e_cnt;
        return v;
    endfunction

    localparam logic [31:0] A = 32'hAAAA0001, B = 32'hBBBB0002, C = 32'hCCCC0003;
    localparam logic [31:0] D = 32'hDDDD0004, E = 32'hEEEE0005;

    vec_t vecs[28];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req_valid = 0; req_dest = 0; req_len = 0; data = 0; data_valid = 0; ready = 1'b1;
        req_valid2 = 0; ready2 = 2'b00;

        //           rv dst len  d   dv rdy  rr dr v  type   data          busy cnt
        vecs[0]  = mk(0, 0, 0,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 0);
        vecs[1]  = mk(1, 3, 0,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 0);
        vecs[2]  = mk(0, 0, 0,   0,  0, 1,   1, 0, 1, 2'd3, 32'h18000000, 1, 0);
        vecs[3]  = mk(1, 2, 3,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 1);
        vecs[4]  = mk(0, 0, 0,   A,  1, 1,   0, 1, 1, 2'd1, 32'h10000003, 1, 1);
        vecs[5]  = mk(0, 0, 0,   B,  1, 1,   0, 1, 1, 2'd0, A,            1, 1);
        vecs[6]  = mk(0, 0, 0,   C,  1, 1,   0, 1, 1, 2'd0, B,            1, 1);
        vecs[7]  = mk(0, 0, 0,   0,  0, 1,   1, 0, 1, 2'd2, C,            1, 1);
        vecs[8]  = mk(0, 0, 0,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 2);
        // same packet, router stalls while B is presented
        vecs[9]  = mk(1, 2, 3,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 2);
        vecs[10] = mk(0, 0, 0,   A,  1, 1,   0, 1, 1, 2'd1, 32'h10000003, 1, 2);
        vecs[11] = mk(0, 0, 0,   B,  1, 1,   0, 1, 1, 2'd0, A,            1, 2);
        vecs[12] = mk(0, 0, 0,   C,  1, 0,   0, 0, 1, 2'd0, B,            1, 2);
        vecs[13] = mk(0, 0, 0,   C,  1, 0,   0, 0, 1, 2'd0, B,            1, 2);
        vecs[14] = mk(0, 0, 0,   C,  1, 0,   0, 0, 1, 2'd0, B,            1, 2);
        vecs[15] = mk(0, 0, 0,   C,  1, 1,   0, 1, 1, 2'd0, B,            1, 2);
        vecs[16] = mk(0, 0, 0,   0,  0, 1,   1, 0, 1, 2'd2, C,            1, 2);
        // two len=1 packets back to back
        vecs[17] = mk(1, 1, 1,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 3);
        vecs[18] = mk(1, 4, 1,   D,  1, 1,   0, 1, 1, 2'd1, 32'h08000001, 1, 3);
        vecs[19] = mk(1, 4, 1,   E,  1, 1,   1, 0, 1, 2'd2, D,            1, 3);
        vecs[20] = mk(0, 0, 0,   E,  1, 1,   0, 1, 1, 2'd1, 32'h20000001, 1, 4);
        vecs[21] = mk(0, 0, 0,   0,  0, 1,   1, 0, 1, 2'd2, E,            1, 4);
        vecs[22] = mk(0, 0, 0,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 5);
        // single flits with output blocked, then drain+load in one cycle
        vecs[23] = mk(1, 5, 0,   0,  0, 0,   1, 0, 0, 2'd0, 32'h0,        0, 5);
        vecs[24] = mk(1, 6, 0,   0,  0, 0,   0, 0, 1, 2'd3, 32'h28000000, 1, 5);
        vecs[25] = mk(1, 6, 0,   0,  0, 1,   1, 0, 1, 2'd3, 32'h28000000, 1, 5);
        vecs[26] = mk(0, 0, 0,   0,  0, 1,   1, 0, 1, 2'd3, 32'h30000000, 1, 6);
        vecs[27] = mk(0, 0, 0,   0,  0, 1,   1, 0, 0, 2'd0, 32'h0,        0, 7);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_flit", 64'(flit), 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_cnt", 64'(pkt_cnt), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_data_ready", 64'(data_ready), 64'h0);
        check("rst_vc_valid", 64'(valid2), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            req_valid = vecs[i].rv; req_dest = vecs[i].dest; req_len = vecs[i].len;
            data = vecs[i].d; data_valid = vecs[i].dv; ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_rr));
            check($sformatf("v%0d_data_ready", i), 64'(data_ready), 64'(vecs[i].e_dr));
            check($sformatf("v%0d_valid", i), 64'(valid), 64'(vecs[i].e_v));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("v%0d_cnt", i), 64'(pkt_cnt), 64'(vecs[i].e_cnt));
            if (vecs[i].e_v)
                check($sformatf("v%0d_flit", i), 64'(flit), 64'({vecs[i].e_type, vecs[i].e_data}));
        end

        // maximum length packet: 255 payload flits
        @(negedge clk);
        req_valid = 1; req_dest = 5'd9; req_len = 8'd255; data_valid = 0; ready = 1;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            req_valid = 0; data = 32'h5000_0000 + 32'(i); data_valid = 1;
            #1;
            check($sformatf("max_dr%0d", i), 64'(data_ready), 64'h1);
            if (i == 0)
                check("max_hdr", 64'(flit), {30'd0, 2'b01, 32'h480000FF});
            else
                check($sformatf("max_pl%0d", i), 64'(flit), {30'd0, 2'b00, 32'h5000_0000 + 32'(i - 1)});
        end
        @(negedge clk);
        data_valid = 0;
        #1;
        check("max_last", 64'(flit), {30'd0, 2'b10, 32'h5000_00FE});
        check("max_last_valid", 64'(valid), 64'h1);
        @(negedge clk);
        #1;
        check("max_cnt", 64'(pkt_cnt), 64'd8);
        check("max_busy", 64'(busy), 64'h0);

        // reset during a len=4 worm
        req_valid = 1; req_dest = 5'd2; req_len = 8'd4;
        @(negedge clk);
        req_valid = 0; data = A; data_valid = 0;
        #1;
        check("mid_hdr", 64'(flit), {30'd0, 2'b01, 32'h10000004});
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(valid), 64'h0);
        check("mid_rst_cnt", 64'(pkt_cnt), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1; req_dest = 5'd7; req_len = 8'd0; data_valid = 1;
        #1;
        check("mid_req_ready", 64'(req_ready), 64'h1);
        check("mid_data_ready", 64'(data_ready), 64'h0);
        @(negedge clk);
        req_valid = 0; data_valid = 0;
        #1;
        check("mid_fresh", 64'(flit), {30'd0, 2'b11, 32'h38000000});
        check("mid_fresh_valid", 64'(valid), 64'h1);
        @(negedge clk);
        #1;
        check("mid_fresh_cnt", 64'(pkt_cnt), 64'h1);

        // second virtual channel instance
        req_valid2 = 1; ready2 = 2'b01;
        @(negedge clk);
        req_valid2 = 0;
        #1;
        check("vc_valid", 64'(valid2), 64'h2);
        check("vc_flit", 64'(flit2), {30'd0, 2'b11, 32'h08000000});
        @(negedge clk);
        req_valid2 = 1;
        #1;
        check("vc_stall_valid", 64'(valid2), 64'h2);
        check("vc_stall_rr", 64'(req_ready2), 64'h0);
        check("vc_stall_cnt", 64'(pkt_cnt2), 64'h0);
        @(negedge clk);
        req_valid2 = 0; ready2 = 2'b10;
        @(negedge clk);
        #1;
        check("vc_drained", 64'(valid2), 64'h0);
        check("vc_cnt", 64'(pkt_cnt2), 64'h1);
        check("vc_busy", 64'(busy2), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
